// File: rtl/addr_skew_gen.sv
// Self-sequencing skewed read-address generator for the weight/data SRAMs
// feeding the systolic array queue groups; group g trails group 0 by g*GRP_SKEW cycles.
module addr_skew_gen #(
  parameter int                NUM_GRP   = 4,
  parameter int                GRP_SKEW  = 4,
  parameter int                ADDR_W    = 10,
  parameter int                LEN_W     = 7,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = ADDR_W'(127)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LEN_W-1:0]          tile_len,
  input  logic [ADDR_W-1:0]         base_w,
  input  logic [ADDR_W-1:0]         base_d,
  input  logic                      stall,
  output logic [NUM_GRP*ADDR_W-1:0] sram_raddr_w,
  output logic [NUM_GRP*ADDR_W-1:0] sram_raddr_d,
  output logic [NUM_GRP-1:0]        grp_valid,
  output logic                      busy,
  output logic                      done
);

  localparam int SPAN  = (NUM_GRP - 1) * GRP_SKEW;
  localparam int CNT_W = LEN_W + $clog2(SPAN + 1) + 1;

  localparam logic [NUM_GRP*ADDR_W-1:0] IDLE_VEC = {NUM_GRP{IDLE_ADDR}};

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                    state_q, state_n;
  logic [LEN_W-1:0]          len_q, len_n;
  logic [ADDR_W-1:0]         base_w_q, base_w_n;
  logic [ADDR_W-1:0]         base_d_q, base_d_n;
  logic [CNT_W-1:0]          cnt_q, cnt_n;
  logic [NUM_GRP*ADDR_W-1:0] raddr_w_q, raddr_w_n;
  logic [NUM_GRP*ADDR_W-1:0] raddr_d_q, raddr_d_n;
  logic [NUM_GRP-1:0]        valid_q, valid_n;
  logic                      busy_q, busy_n;
  logic                      done_q, done_n;

  // Per-group addresses for the current count, consumed by the RUN state.
  logic [NUM_GRP*ADDR_W-1:0] sweep_w;
  logic [NUM_GRP*ADDR_W-1:0] sweep_d;
  logic [NUM_GRP-1:0]        sweep_v;
  logic [CNT_W-1:0]          cnt_end;

  // cnt_end is LAST+1, written so that tile_len-1 never underflows.
  assign cnt_end = CNT_W'(len_q) + CNT_W'(SPAN);

  always_comb begin
    logic [CNT_W-1:0] grp_start;
    logic [CNT_W-1:0] off;
    // NOTE: every combinational output gets a default before any branch, so no path
    // can leave a signal unassigned and infer a latch.
    sweep_w   = IDLE_VEC;
    sweep_d   = IDLE_VEC;
    sweep_v   = '0;
    grp_start = '0;
    off       = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      grp_start = CNT_W'(g * GRP_SKEW);
      off       = cnt_q - grp_start;
      if ((cnt_q >= grp_start) && (off < CNT_W'(len_q))) begin
        sweep_w[g*ADDR_W +: ADDR_W] = base_w_q + ADDR_W'(off);
        sweep_d[g*ADDR_W +: ADDR_W] = base_d_q + ADDR_W'(off);
        sweep_v[g]                  = 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    len_n     = len_q;
    base_w_n  = base_w_q;
    base_d_n  = base_d_q;
    cnt_n     = cnt_q;
    raddr_w_n = raddr_w_q;
    raddr_d_n = raddr_d_q;
    valid_n   = valid_q;
    busy_n    = busy_q;
    done_n    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        raddr_w_n = IDLE_VEC;
        raddr_d_n = IDLE_VEC;
        valid_n   = '0;
        busy_n    = 1'b0;
        if (start) begin
          if (tile_len != '0) begin
            len_n    = tile_len;
            base_w_n = base_w;
            base_d_n = base_d;
            cnt_n    = '0;
            busy_n   = 1'b1;
            state_n  = S_RUN;
          end else begin
            // Empty sweep: acknowledge immediately without ever going busy.
            done_n = 1'b1;
          end
        end
      end

      S_RUN: begin
        if (stall) begin
          done_n = done_q;
        end else if (cnt_q == cnt_end) begin
          raddr_w_n = IDLE_VEC;
          raddr_d_n = IDLE_VEC;
          valid_n   = '0;
          busy_n    = 1'b0;
          done_n    = 1'b1;
          state_n   = S_IDLE;
        end else begin
          raddr_w_n = sweep_w;
          raddr_d_n = sweep_d;
          valid_n   = sweep_v;
          cnt_n     = cnt_q + 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // Address registers reset to IDLE_ADDR so the SRAMs see the zeroed row straight
  // out of reset or after an aborted sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      base_w_q  <= '0;
      base_d_q  <= '0;
      cnt_q     <= '0;
      raddr_w_q <= IDLE_VEC;
      raddr_d_q <= IDLE_VEC;
      valid_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values,
      // independent of statement order.
      state_q   <= state_n;
      len_q     <= len_n;
      base_w_q  <= base_w_n;
      base_d_q  <= base_d_n;
      cnt_q     <= cnt_n;
      raddr_w_q <= raddr_w_n;
      raddr_d_q <= raddr_d_n;
      valid_q   <= valid_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
    end
  end

  assign sram_raddr_w = raddr_w_q;
  assign sram_raddr_d = raddr_d_q;
  assign grp_valid    = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_addr_skew_gen.sv
// Directed self-checking bench for addr_skew_gen at default parameters:
// a table of per-edge expectations for the long sweep plus hand-written corner sequences.
module tb_addr_skew_gen;

  localparam int AW = 10;
  localparam int NG = 4;
  localparam int LW = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stall = 1'b0;
  logic [LW-1:0]    tile_len = '0;
  logic [AW-1:0]    base_w = '0;
  logic [AW-1:0]    base_d = '0;
  logic [NG*AW-1:0] sram_raddr_w;
  logic [NG*AW-1:0] sram_raddr_d;
  logic [NG-1:0]    grp_valid;
  logic             busy;
  logic             done;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int            edge_n;
    logic [NG*AW-1:0] w;
    logic [NG-1:0] v;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t tbl[9];

  addr_skew_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .tile_len     (tile_len),
    .base_w       (base_w),
    .base_d       (base_d),
    .stall        (stall),
    .sram_raddr_w (sram_raddr_w),
    .sram_raddr_d (sram_raddr_d),
    .grp_valid    (grp_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic logic [NG*AW-1:0] pack4(input int a0, input int a1, input int a2, input int a3);
    return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents start for exactly one edge (E0); returns 1 time unit after E0.
  task automatic begin_sweep(input int len, input int bw, input int bd);
    tile_len = LW'(len);
    base_w   = AW'(bw);
    base_d   = AW'(bd);
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " raddr_w"}, 64'(sram_raddr_w), 64'(v.w));
    check({tag, " raddr_d"}, 64'(sram_raddr_d), 64'(v.w));
    check({tag, " grp_valid"}, 64'(grp_valid), 64'(v.v));
    check({tag, " busy"}, 64'(busy), 64'(v.busy));
    check({tag, " done"}, 64'(done), 64'(v.done));
  endtask

  initial begin
    logic [NG*AW-1:0] idle_v;
    int idx;
    int exp_w0[8];
    idle_v = pack4(127, 127, 127, 127);
    exp_w0 = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};

    // Long sweep, tile_len=99, bases 0: LAST = 98 + 12 = 110.
    tbl[0] = '{1,   pack4(0, 127, 127, 127),   4'b0001, 1'b1, 1'b0};
    tbl[1] = '{4,   pack4(3, 127, 127, 127),   4'b0001, 1'b1, 1'b0};
    tbl[2] = '{5,   pack4(4, 0, 127, 127),     4'b0011, 1'b1, 1'b0};
    tbl[3] = '{9,   pack4(8, 4, 0, 127),       4'b0111, 1'b1, 1'b0};
    tbl[4] = '{13,  pack4(12, 8, 4, 0),        4'b1111, 1'b1, 1'b0};
    tbl[5] = '{99,  pack4(98, 94, 90, 86),     4'b1111, 1'b1, 1'b0};
    tbl[6] = '{100, pack4(127, 95, 91, 87),    4'b1110, 1'b1, 1'b0};
    tbl[7] = '{111, pack4(127, 127, 127, 98),  4'b1000, 1'b1, 1'b0};
    tbl[8] = '{112, pack4(127, 127, 127, 127), 4'b0000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset raddr_w", 64'(sram_raddr_w), 64'(idle_v));
    check("reset raddr_d", 64'(sram_raddr_d), 64'(idle_v));
    check("reset grp_valid", 64'(grp_valid), 64'(0));
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Case 1: legacy equivalence
    begin_sweep(99, 0, 0);
    check("c1 busy after E0", 64'(busy), 64'(1));
    idx = 0;
    for (int e = 1; e <= 113; e++) begin
      tick();
      if (idx < 9 && tbl[idx].edge_n == e) begin
        check_vec($sformatf("c1 E%0d", e), tbl[idx]);
        idx++;
      end
      if (e == 113) begin
        check("c1 done single pulse", 64'(done), 64'(0));
        check("c1 idle after done", 64'(sram_raddr_w), 64'(idle_v));
      end
    end

    // Case 2: base offsets and address wrap
    begin_sweep(8, 1020, 5);
    for (int e = 1; e <= 21; e++) begin
      tick();
      if (e <= 8) begin
        check($sformatf("c2 E%0d g0 w", e), 64'(sram_raddr_w[0 +: AW]), 64'(exp_w0[e-1]));
        check($sformatf("c2 E%0d g0 d", e), 64'(sram_raddr_d[0 +: AW]), 64'(5 + e - 1));
      end
      if (e >= 5 && e <= 12) begin
        check($sformatf("c2 E%0d g1 w", e), 64'(sram_raddr_w[AW +: AW]), 64'(exp_w0[e-5]));
        check($sformatf("c2 E%0d g1 d", e), 64'(sram_raddr_d[AW +: AW]), 64'(5 + e - 5));
      end
      if (e == 9) check("c2 E9 g0 idle", 64'(sram_raddr_w[0 +: AW]), 64'(127));
      if (e == 20) begin
        check("c2 E20 g3 w", 64'(sram_raddr_w[3*AW +: AW]), 64'(3));
        check("c2 E20 g3 d", 64'(sram_raddr_d[3*AW +: AW]), 64'(12));
        check("c2 E20 done", 64'(done), 64'(0));
      end
      if (e == 21) begin
        check("c2 E21 done", 64'(done), 64'(1));
        check("c2 E21 busy", 64'(busy), 64'(0));
      end
    end
    tick();

    // Case 3: stall sampled at E21..E23 freezes the E20 outputs
    begin_sweep(99, 0, 0);
    for (int e = 1; e <= 116; e++) begin
      tick();
      if (e == 20) begin
        check("c3 E20 w", 64'(sram_raddr_w), 64'(pack4(19, 15, 11, 7)));
        stall = 1'b1;
      end
      if (e >= 21 && e <= 23) begin
        check($sformatf("c3 E%0d frozen w", e), 64'(sram_raddr_w), 64'(pack4(19, 15, 11, 7)));
        check($sformatf("c3 E%0d frozen d", e), 64'(sram_raddr_d), 64'(pack4(19, 15, 11, 7)));
        check($sformatf("c3 E%0d busy", e), 64'(busy), 64'(1));
      end
      if (e == 23) stall = 1'b0;
      if (e == 24) check("c3 E24 resume", 64'(sram_raddr_w), 64'(pack4(20, 16, 12, 8)));
      if (e == 114) begin
        check("c3 E114 last", 64'(sram_raddr_w), 64'(pack4(127, 127, 127, 98)));
        check("c3 E114 done", 64'(done), 64'(0));
      end
      if (e == 115) begin
        check("c3 E115 done", 64'(done), 64'(1));
        check("c3 E115 busy", 64'(busy), 64'(0));
      end
    end

    // Case 4: start during a sweep is ignored; start in the done cycle is accepted
    begin_sweep(4, 0, 0);
    for (int e = 1; e <= 17; e++) begin
      tick();
      if (e == 9) begin
        start    = 1'b1;
        tile_len = LW'(50);
        base_w   = AW'(200);
      end
      if (e == 10) begin
        start    = 1'b0;
        tile_len = LW'(4);
        base_w   = AW'(0);
      end
      if (e == 11) check("c4 ignored start", 64'(sram_raddr_w), 64'(pack4(127, 127, 2, 127)));
      if (e == 16) check("c4 E16 done", 64'(done), 64'(0));
      if (e == 17) begin
        check("c4 E17 done", 64'(done), 64'(1));
        check("c4 E17 busy", 64'(busy), 64'(0));
      end
    end
    start    = 1'b1;
    tile_len = LW'(4);
    base_w   = AW'(300);
    base_d   = AW'(400);
    tick();
    start = 1'b0;
    check("c4 E18 busy", 64'(busy), 64'(1));
    check("c4 E18 done", 64'(done), 64'(0));
    check("c4 E18 idle", 64'(sram_raddr_w), 64'(idle_v));
    tick();
    check("c4 E19 w", 64'(sram_raddr_w), 64'(pack4(300, 127, 127, 127)));
    check("c4 E19 d", 64'(sram_raddr_d), 64'(pack4(400, 127, 127, 127)));
    check("c4 E19 valid", 64'(grp_valid), 64'(4'b0001));
    for (int e = 20; e <= 35; e++) begin
      tick();
      if (e == 34) check("c4 E34 done", 64'(done), 64'(0));
      if (e == 35) check("c4 E35 done", 64'(done), 64'(1));
    end
    tick();

    // Case 5: zero-length sweep acknowledges at the accepting edge only
    begin_sweep(0, 0, 0);
    check("c5 done", 64'(done), 64'(1));
    check("c5 busy", 64'(busy), 64'(0));
    check("c5 w", 64'(sram_raddr_w), 64'(idle_v));
    check("c5 valid", 64'(grp_valid), 64'(0));
    tick();
    check("c5 done drop", 64'(done), 64'(0));
    check("c5 busy after", 64'(busy), 64'(0));

    // Case 6: asynchronous reset mid-sweep
    begin_sweep(99, 0, 0);
    repeat (50) tick();
    check("c6 E50 g0", 64'(sram_raddr_w[0 +: AW]), 64'(49));
    #2;
    rst_n = 1'b0;
    #1;
    check("c6 async w", 64'(sram_raddr_w), 64'(idle_v));
    check("c6 async d", 64'(sram_raddr_d), 64'(idle_v));
    check("c6 async valid", 64'(grp_valid), 64'(0));
    check("c6 async busy", 64'(busy), 64'(0));
    check("c6 async done", 64'(done), 64'(0));
    repeat (2) tick();
    check("c6 no done in reset", 64'(done), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("c6 no done after release", 64'(done), 64'(0));
    begin_sweep(99, 0, 0);
    idx = 0;
    for (int e = 1; e <= 13; e++) begin
      tick();
      if (idx < 5 && tbl[idx].edge_n == e) begin
        check_vec($sformatf("c6 E%0d", e), tbl[idx]);
        idx++;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addr_skew_gen.md
Name: addr_skew_gen

Overview:
Parametrised, self-sequencing successor to the fixed 4-group skewed SRAM read-address selector feeding the systolic array queues. Given a start pulse, tile length and weight/data base addresses, it walks an internal counter and emits per-group skewed read addresses for weight and data SRAMs. Idle groups are driven to IDLE_ADDR, with stall, busy and done handshakes. Sits between the top-level controller and the weight/data SRAM read ports.

Parameters:
NUM_GRP, 4, number of queue groups (one weight and one data read port each)
GRP_SKEW, 4, cycle skew between consecutive groups
ADDR_W, 10, SRAM address width
LEN_W, 7, width of tile_len input
IDLE_ADDR, 127, address driven by an inactive group (points at zeroed row)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request a tile sweep; sampled only in IDLE
tile_len  input  LEN_W  rows per group for this sweep; latched on accepted start
base_w  input  ADDR_W  weight base address; latched on accepted start
base_d  input  ADDR_W  data base address; latched on accepted start
stall  input  1  freeze sweep while high (RUN only)
sram_raddr_w  output  NUM_GRP*ADDR_W  group g at [g*ADDR_W +: ADDR_W]
sram_raddr_d  output  NUM_GRP*ADDR_W  same packing
grp_valid  output  NUM_GRP  bit g = group g address is real (not IDLE_ADDR fill)
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at sweep end

Behaviour:
- Reset (async, rst_n=0): state IDLE, counter 0, all address slots = IDLE_ADDR, grp_valid=0, busy=0, done=0. Takes effect immediately mid-sweep; no done pulse is issued for an aborted sweep.
- States: IDLE, RUN. All outputs registered.
- IDLE: edge E0 with start=1 and tile_len>0: latch tile_len/base_w/base_d, cnt<=0, busy<=1, go RUN. If tile_len=0: stay IDLE, done<=1 for one cycle, busy stays 0, outputs idle.
- start while busy (RUN): ignored. stall in IDLE: ignored.
- LAST = tile_len-1 + (NUM_GRP-1)*GRP_SKEW. Internal counter wide enough for LAST+1, i.e. LEN_W + clog2((NUM_GRP-1)*GRP_SKEW+1) + 1 bits.
- RUN, stall=0, cnt<=LAST: for each g, off = cnt - g*GRP_SKEW.
  - Group active iff 0 <= off <= tile_len-1.
  - Active: raddr_w[g] <= base_w+off, raddr_d[g] <= base_d+off (mod 2^ADDR_W, wraps silently), grp_valid[g] <= 1.
  - Inactive: IDLE_ADDR, grp_valid[g] <= 0.
  - cnt <= cnt+1.
- RUN, stall=0, cnt==LAST+1: all slots IDLE_ADDR, grp_valid=0, done<=1, busy<=0, go IDLE.
- RUN, stall=1: cnt, addresses, grp_valid held; done/busy unchanged. Each stalled cycle delays every later edge by one.
- Timing, no stalls:
  - Value for cnt=c appears after edge E(c+1).
  - Group g first address at E(1+g*GRP_SKEW).
  - Last address at E(LAST+1); done=1 and busy=0 at E(LAST+2).
  - Sweep occupies LAST+2 cycles after start.
- done is a single-cycle pulse. State is IDLE in the done cycle, so start high in that cycle is accepted at the next edge (back-to-back sweeps, one idle-address cycle between).
- Weight and data paths share cnt and the skew; only the bases differ.

Test Plan:
1. Legacy equivalence (defaults, base_w=base_d=0, tile_len=99, start at E0):
   - E1: w=[0,127,127,127], grp_valid=0001.
   - E5: [4,0,127,127].
   - E13: [12,8,4,0].
   - E99: w0=98. E100: w0=127, w1=95.
   - E111: w3=98, others 127.
   - E112: all 127, done=1, busy=0. d identical.
2. Base/wrap: base_w=1020, base_d=5, tile_len=8 -> group0 w sequence 1020,1021,1022,1023,0,1,2,3; d 5..12; group1 same, 4 cycles later; done at E(7+12+2)=E21.
3. Stall: case 1 with stall=1 during cycles E20-E22 -> addresses frozen at their E20 values for 3 cycles, sequence resumes unchanged, done at E115.
4. Handshake: start pulses at E30 during a sweep -> ignored, no second sweep. Start held in the done cycle -> new sweep's first address one cycle after the next edge.
5. tile_len=0 -> done=1 at E1 only, busy never 1, outputs stay 127, grp_valid=0.
6. rst_n low mid-sweep at E50 (async, between edges) -> all slots 127, grp_valid=0, busy=0 immediately, no done. After release, a fresh start behaves as in case 1.
